id_stage: RTL

- Instruction-decode stage of the 4-stage 16-bit pipeline (IF -> ID -> EX -> WB).
- Holds the architectural register file, decodes the instruction fields, reads two source operands and produces a 16-bit immediate.
- Its outputs drive the inputs of the ID/EX pipeline register. The WB stage writes results back through the write port.
- Decode and read are combinational from inst_in. State lives in the register file.

---
 rtl/cpu_pkg.sv | 31 +++
 rtl/regfile_8x16.sv | 46 ++++
 rtl/id_stage.sv | 58 +++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit pipeline: widths, opcodes and instruction field positions.
// Used by the ID, EX and WB stages.
package cpu_pkg;

  localparam int DATA_W     = 16;
  localparam int NREGS      = 8;
  localparam int REG_ADDR_W = 3;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_XOR  = 4'h5;
  localparam logic [3:0] OP_ADDI = 4'h6;
  localparam logic [3:0] OP_LDI  = 4'h7;
  localparam logic [3:0] OP_LD   = 4'h8;
  localparam logic [3:0] OP_ST   = 4'h9;
  localparam logic [3:0] OP_BEQ  = 4'hA;
  localparam logic [3:0] OP_JMP  = 4'hB;

  localparam int OP_MSB  = 15;
  localparam int OP_LSB  = 12;
  localparam int RD_MSB  = 11;
  localparam int RD_LSB  = 9;
  localparam int RS1_MSB = 8;
  localparam int RS1_LSB = 6;
  localparam int RS2_MSB = 5;
  localparam int RS2_LSB = 3;

endpackage

// File: rtl/regfile_8x16.sv
// Architectural register file: async-reset storage, one write port and three
// combinational read ports with R0 hardwired to zero and write-through bypass.
module regfile_8x16
  import cpu_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  we,
  input  logic [REG_ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0]     wdata,
  input  logic [REG_ADDR_W-1:0] raddr_a,
  input  logic [REG_ADDR_W-1:0] raddr_b,
  input  logic [REG_ADDR_W-1:0] raddr_c,
  output logic [DATA_W-1:0]     rdata_a,
  output logic [DATA_W-1:0]     rdata_b,
  output logic [DATA_W-1:0]     rdata_c
);

  logic [DATA_W-1:0] regs [NREGS];
  logic              write_active;

  assign write_active = !reset && we && (waddr != '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (write_active) begin
      regs[waddr] <= wdata;
    end
  end

  // Each port: zero during reset, then bypass, then R0 forced to zero, then storage.
  function automatic logic [DATA_W-1:0] read_port(input logic [REG_ADDR_W-1:0] a);
    if (reset)                            return '0;
    else if (write_active && waddr == a)  return wdata;
    else if (a == '0)                     return '0;
    else                                  return regs[a];
  endfunction

  always_comb begin
    rdata_a = read_port(raddr_a);
    rdata_b = read_port(raddr_b);
    rdata_c = read_port(raddr_c);
  end

endmodule

// File: rtl/id_stage.sv
// Instruction-decode stage: field extraction, immediate generation and operand
// read from the register file; ST reads its store data from rd on port B.
module id_stage
  import cpu_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic [15:0]           inst_in,
  input  logic                  wb_en,
  input  logic [REG_ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0]     wb_data,
  input  logic [REG_ADDR_W-1:0] dbg_addr,
  output logic [15:0]           inst_out,
  output logic [DATA_W-1:0]     data1_out,
  output logic [DATA_W-1:0]     data2_out,
  output logic [DATA_W-1:0]     imm_out,
  output logic [DATA_W-1:0]     dbg_data
);

  logic [3:0]            op;
  logic [REG_ADDR_W-1:0] rd;
  logic [REG_ADDR_W-1:0] rs1;
  logic [REG_ADDR_W-1:0] rs2;
  logic [REG_ADDR_W-1:0] addr_b;

  assign op  = inst_in[OP_MSB:OP_LSB];
  assign rd  = inst_in[RD_MSB:RD_LSB];
  assign rs1 = inst_in[RS1_MSB:RS1_LSB];
  assign rs2 = inst_in[RS2_MSB:RS2_LSB];

  assign addr_b   = (op == OP_ST) ? rd : rs2;
  assign inst_out = inst_in;

  always_comb begin
    imm_out = '0;
    case (op)
      OP_ADDI, OP_LD, OP_ST, OP_BEQ: imm_out = {{10{inst_in[5]}}, inst_in[5:0]};
      OP_LDI:                        imm_out = {7'b0, inst_in[8:0]};
      OP_JMP:                        imm_out = {{4{inst_in[11]}}, inst_in[11:0]};
      default:                       imm_out = '0;
    endcase
  end

  regfile_8x16 u_regfile (
    .clk     (clk),
    .reset   (reset),
    .we      (wb_en),
    .waddr   (wb_addr),
    .wdata   (wb_data),
    .raddr_a (rs1),
    .raddr_b (addr_b),
    .raddr_c (dbg_addr),
    .rdata_a (data1_out),
    .rdata_b (data2_out),
    .rdata_c (dbg_data)
  );

endmodule
